// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU command and operand selects, and handshakes with a wait-stated memory.
module mips_multicycle_control #(
  parameter int ALU_OP_W = 4,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  input  logic                mem_ready_i,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                i_or_d_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_source_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_operation_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                illegal_o,
  output logic [STATE_W-1:0]  state_o
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    I_EXEC    = 4'd8,
    I_WB      = 4'd9,
    JUMP      = 4'd10,
    TRAP      = 4'd11
  } state_e;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0011);
  localparam logic [ALU_OP_W-1:0] ALU_LUI = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'b0001);
  localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(4'b0010);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLL   = 6'b000000;

  state_e state_q, state_d;

  logic                mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]          pc_source, alu_src_b;
  logic                alu_src_a, reg_write, reg_dst, mem_to_reg;
  logic [ALU_OP_W-1:0] alu_op, r_alu_op, i_alu_op;
  logic [1:0]          i_src_b;
  logic                r_legal;

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    r_legal  = (funct_i == FN_ADD) || (funct_i == FN_OR) || (funct_i == FN_SLL);
    r_alu_op = ALU_ADD;
    if (funct_i == FN_OR)       r_alu_op = ALU_OR;
    else if (funct_i == FN_SLL) r_alu_op = ALU_SLL;
    i_src_b  = 2'b11;
    i_alu_op = ALU_OR;
    if (opcode_i == OP_ADDI) begin
      i_src_b  = 2'b10;
      i_alu_op = ALU_ADD;
    end else if (opcode_i == OP_LUI) begin
      i_alu_op = ALU_LUI;
    end

    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = '0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready_i;
        pc_write  = mem_ready_i;
        if (mem_ready_i) state_d = DECODE;
      end
      DECODE: begin
        case (opcode_i)
          OP_RTYPE:               state_d = r_legal ? R_EXEC : TRAP;
          OP_ADDI, OP_ORI, OP_LUI: state_d = I_EXEC;
          OP_LW, OP_SW:           state_d = MEM_ADDR;
          OP_J:                   state_d = JUMP;
          default:                state_d = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready_i) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready_i) state_d = FETCH;
      end
      R_EXEC, R_WB: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        reg_write = (state_q == R_WB);
        reg_dst   = (state_q == R_WB);
        state_d   = (state_q == R_EXEC) ? R_WB : FETCH;
      end
      I_EXEC, I_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = i_src_b;
        alu_op    = i_alu_op;
        reg_write = (state_q == I_WB);
        state_d   = (state_q == I_EXEC) ? I_WB : FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced low combinationally while reset is held, not just at the next edge.
  assign mem_read_o      = reset & mem_read;
  assign mem_write_o     = reset & mem_write;
  assign i_or_d_o        = reset & i_or_d;
  assign ir_write_o      = reset & ir_write;
  assign pc_write_o      = reset & pc_write;
  assign pc_source_o     = reset ? pc_source : 2'b00;
  assign alu_src_a_o     = reset & alu_src_a;
  assign alu_src_b_o     = reset ? alu_src_b : 2'b00;
  assign alu_operation_o = reset ? alu_op : '0;
  assign reg_write_o     = reset & reg_write;
  assign reg_dst_o       = reset & reg_dst;
  assign mem_to_reg_o    = reset & mem_to_reg;
  assign illegal_o       = reset & (state_q == TRAP);
  assign state_o         = reset ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle comparison against a
// phase-sequence model derived from instruction class and memory wait counts.
module tb_mips_multicycle_control;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_MADDR, P_MREAD, P_MWB, P_MWRITE,
                P_REXEC, P_RWB, P_IEXEC, P_IWB, P_JUMP, P_TRAP} phase_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       is_fetch;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o;
  logic [1:0] pc_source_o, alu_src_b_o;
  logic       alu_src_a_o, reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o;
  logic [3:0] alu_operation_o, state_o;

  always #5 clk = ~clk;

  mips_multicycle_control #(.ALU_OP_W(4), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode), .funct_i(funct), .mem_ready_i(mem_ready),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .i_or_d_o(i_or_d_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_source_o(pc_source_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_operation_o(alu_operation_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  outs_t act;
  assign act = {mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_source_o,
                alu_src_a_o, alu_src_b_o, alu_operation_o, reg_write_o, reg_dst_o,
                mem_to_reg_o, illegal_o, (state_o == 4'd0)};

  int    n_checks = 0;
  int    n_fail = 0;
  outs_t exp_o;
  logic  exp_valid = 1'b0;
  string exp_name = "";
  string cur_name = "";

  int         samp_idx, last_busy, ir_cnt, mtr_cnt, mw_cnt, pcw_cnt, ill_cnt;
  logic [3:0] exec_alu;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Expected outputs for one cycle of a phase, straight from the per-state output rules.
  function automatic outs_t model(input phase_e ph, input logic rdy, input logic [5:0] op,
                                  input logic [5:0] fn);
    outs_t o = '0;
    case (ph)
      P_RESET: o.is_fetch = 1'b1;
      P_FETCH: begin
        o.is_fetch = 1'b1; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 4'b0011;
        o.ir_write = rdy;  o.pc_write = rdy;
      end
      P_MADDR:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 4'b0011; end
      P_MREAD:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      P_MWB:    begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      P_MWRITE: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
      P_REXEC, P_RWB: begin
        o.alu_src_a = 1'b1;
        o.alu_op = (fn == 6'b100000) ? 4'b0011 : (fn == 6'b100101) ? 4'b0001 : 4'b0010;
        if (ph == P_RWB) begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      end
      P_IEXEC, P_IWB: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = (op == 6'b001000) ? 2'b10 : 2'b11;
        o.alu_op = (op == 6'b001000) ? 4'b0011 : (op == 6'b001101) ? 4'b0001 : 4'b0000;
        o.reg_write = (ph == P_IWB);
      end
      P_JUMP: begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
      P_TRAP: o.illegal = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  always @(negedge clk) if (exp_valid) check(exp_name, 32'(act), 32'(exp_o));

  task automatic step(input phase_e ph, input logic rdy);
    @(posedge clk); #1;
    mem_ready = rdy;
    exp_o     = model(ph, rdy, opcode, funct);
    exp_name  = {cur_name, ":", ph.name()};
    exp_valid = 1'b1;
    @(negedge clk); #1;
    samp_idx++;
    if (!act.is_fetch) last_busy = samp_idx;
    if (act.ir_write)   ir_cnt++;
    if (act.mem_to_reg) mtr_cnt++;
    if (act.mem_write)  mw_cnt++;
    if (act.pc_write)   pcw_cnt++;
    if (act.illegal)    ill_cnt++;
    if (ph == P_REXEC || ph == P_IEXEC) exec_alu = act.alu_op;
  endtask

  task automatic start_instr(input string nm, input logic [5:0] op, input logic [5:0] fn);
    cur_name = nm; opcode = op; funct = fn;
    samp_idx = 0; last_busy = 0; ir_cnt = 0; mtr_cnt = 0; mw_cnt = 0; pcw_cnt = 0;
    ill_cnt = 0; exec_alu = 4'hf;
  endtask

  // Build the phase sequence for one instruction and run it; non-memory phases see a
  // toggling mem_ready to show it is ignored there.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw);
    phase_e ph_q[$];
    logic   rdy_q[$];
    logic   r_ok;
    r_ok = (fn == 6'b100000) || (fn == 6'b100101) || (fn == 6'b000000);
    start_instr(nm, op, fn);
    for (int i = 0; i < fw; i++) begin ph_q.push_back(P_FETCH); rdy_q.push_back(1'b0); end
    ph_q.push_back(P_FETCH);  rdy_q.push_back(1'b1);
    ph_q.push_back(P_DECODE); rdy_q.push_back(1'b0);
    if (op == 6'b000000 && r_ok) begin
      ph_q.push_back(P_REXEC); ph_q.push_back(P_RWB);
    end else if (op == 6'b001000 || op == 6'b001101 || op == 6'b001111) begin
      ph_q.push_back(P_IEXEC); ph_q.push_back(P_IWB);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      phase_e mp = (op == 6'b100011) ? P_MREAD : P_MWRITE;
      ph_q.push_back(P_MADDR); rdy_q.push_back(1'b0);
      for (int i = 0; i < mw; i++) begin ph_q.push_back(mp); rdy_q.push_back(1'b0); end
      ph_q.push_back(mp); rdy_q.push_back(1'b1);
      if (op == 6'b100011) ph_q.push_back(P_MWB);
    end else if (op == 6'b000010) begin
      ph_q.push_back(P_JUMP);
    end else begin
      for (int i = 0; i < 20; i++) ph_q.push_back(P_TRAP);
    end
    while (rdy_q.size() < ph_q.size()) rdy_q.push_back(rdy_q.size() % 2 == 1);
    for (int i = 0; i < ph_q.size(); i++) step(ph_q[i], rdy_q[i]);
  endtask

  // Assert reset between clock edges, check outputs before any edge, then release.
  task automatic do_reset(input string nm);
    exp_valid = 1'b0;
    #1 reset = 1'b0; mem_ready = 1'b0;
    #1 check({nm, " async"}, 32'(act), 32'(model(P_RESET, 1'b0, opcode, funct)));
    exp_o = model(P_RESET, 1'b0, opcode, funct); exp_name = {nm, " held"}; exp_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1 check({nm, " rel mem_read"}, 32'(mem_read_o), 32'd1);
    check({nm, " rel i_or_d"}, 32'(i_or_d_o), 32'd0);
    exp_o = model(P_FETCH, 1'b0, opcode, funct); exp_name = {nm, " rel"};
    @(negedge clk); #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 check("init reset", 32'(act), 32'(model(P_RESET, 1'b0, opcode, funct)));
    @(negedge clk); #1;
    do_reset("init");

    start_instr("rst_mid", 6'b100011, 6'b0);
    step(P_FETCH, 1'b1); step(P_DECODE, 1'b1); step(P_MADDR, 1'b1);
    step(P_MREAD, 1'b0); step(P_MREAD, 1'b0);
    do_reset("rst_mid");

    run_instr("add", 6'b000000, 6'b100000, 0, 0);
    check("add len", 32'(last_busy), 32'd4);
    check("add alu", 32'(exec_alu), 32'h3);
    run_instr("sll", 6'b000000, 6'b000000, 0, 0);
    check("sll alu", 32'(exec_alu), 32'h2);
    run_instr("or", 6'b000000, 6'b100101, 0, 0);
    check("or alu", 32'(exec_alu), 32'h1);
    run_instr("addi", 6'b001000, 6'b010101, 0, 0);
    check("addi alu", 32'(exec_alu), 32'h3);
    run_instr("ori", 6'b001101, 6'b000000, 0, 0);
    check("ori alu", 32'(exec_alu), 32'h1);
    run_instr("lui", 6'b001111, 6'b100000, 0, 0);
    check("lui len", 32'(last_busy), 32'd4);
    check("lui alu", 32'(exec_alu), 32'h0);

    run_instr("lw", 6'b100011, 6'b000000, 2, 3);
    check("lw len", 32'(last_busy), 32'd10);
    check("lw ir pulses", 32'(ir_cnt), 32'd1);
    check("lw mem_to_reg", 32'(mtr_cnt), 32'd1);

    run_instr("sw", 6'b101011, 6'b000000, 0, 0);
    check("sw len", 32'(last_busy), 32'd4);
    check("sw mem_write", 32'(mw_cnt), 32'd1);
    run_instr("j", 6'b000010, 6'b000000, 0, 0);
    check("j len", 32'(last_busy), 32'd3);
    check("j pc_write", 32'(pcw_cnt), 32'd2);

    run_instr("trap_op", 6'b111111, 6'b000000, 0, 0);
    check("trap_op illegal", 32'(ill_cnt), 32'd20);
    do_reset("trap_op");
    check("trap_op cleared", 32'(illegal_o), 32'd0);

    run_instr("trap_fn", 6'b000000, 6'b100010, 1, 0);
    check("trap_fn illegal", 32'(ill_cnt), 32'd20);
    check("trap_fn pc_write", 32'(pcw_cnt), 32'd1);
    do_reset("trap_fn");
    check("trap_fn cleared", 32'(illegal_o), 32'd0);

    run_instr("add2", 6'b000000, 6'b100000, 0, 0);
    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
